// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - single-transaction binary (Stein) GCD engine with valid/ready ports
module gcd_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH:0]   iter_o
);

    // Width of the common power-of-two counter k, derived from DATA_WIDTH.
    localparam int SHIFT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ZCHK   = 3'd1,
        S_COMMON = 3'd2,
        S_LOOP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [SHIFT_W-1:0]    k_q, k_d;
    logic [DATA_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH:0]   iter_q, iter_d;

    logic                  both_even;
    logic [DATA_WIDTH:0]   cnt_inc;

    assign both_even = ~a_q[0] & ~b_q[0];
    // Iteration counter saturates at all-ones instead of wrapping.
    assign cnt_inc   = (cnt_q == {(DATA_WIDTH+1){1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d = S_ZCHK;
                end
            end
            S_ZCHK: begin
                if ((a_q == '0) || (b_q == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COMMON;
                end
            end
            S_COMMON: begin
                if (!both_even) begin
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                if (b_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs depend on registered state only.
    always_comb begin
        in_ready_o  = (state_q == S_IDLE);
        out_valid_o = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
    end

    // Datapath next values: one Stein step per cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        k_d    = k_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        iter_d = iter_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    k_d   = '0;
                    cnt_d = '0;
                end
            end
            S_ZCHK: begin
                if (a_q == '0) begin
                    res_d  = b_q;
                    iter_d = cnt_q;
                end else if (b_q == '0) begin
                    res_d  = a_q;
                    iter_d = cnt_q;
                end
            end
            S_COMMON: begin
                cnt_d = cnt_inc;
                if (both_even) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end
            end
            S_LOOP: begin
                cnt_d = cnt_inc;
                if (b_q == '0) begin
                    // a<<k divides both operands, so it always fits.
                    res_d  = a_q << k_q;
                    iter_d = cnt_inc;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = b_q;
                    b_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; res and iter only change on entry to DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            iter_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            iter_q <= iter_d;
        end
    end

    assign res_o  = res_q;
    assign iter_o = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - vector, corner-case and random soak bench for gcd_engine
module tb_gcd_engine;

    localparam int W        = 8;
    localparam int ITER_MAX = 3 * W + 1;
    localparam int N_SOAK   = 2500;
    localparam int BUDGET   = 90000;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] res_o;
    logic         busy_o;
    logic [W:0]   iter_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    gcd_engine #(.DATA_WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o),
        .busy_o      (busy_o),
        .iter_o      (iter_o)
    );

    typedef struct {
        int a;
        int b;
        int res;
        int iter;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference GCD by Euclid's remainder method.
    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Present one pair, wait for the result; latency counts the accept edge as 1.
    task automatic do_txn(input int a, input int b, output int res, output int iter,
                          output int lat, output int rdy_viol);
        int guard = 0;
        @(negedge clk_i);
        a_i = W'(a);
        b_i = W'(b);
        in_valid_i = 1'b1;
        while (!in_ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        check("accept_wait", int'(guard < 100), 1);
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        lat = 1;
        rdy_viol = 0;
        while (!out_valid_o && lat < 200) begin
            if (in_ready_o) rdy_viol++;
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        res  = int'(res_o);
        iter = int'(iter_o);
    endtask

    vec_t vecs[8];
    int   res, iter, lat, viol;
    int   exp_q[$];
    int   rcvd;
    int   cyc;
    bit   timeout;

    initial begin
        vecs[0] = '{48, 18, 6, 9};
        vecs[1] = '{0, 0, 0, 0};
        vecs[2] = '{0, 9, 9, 0};
        vecs[3] = '{9, 0, 9, 0};
        vecs[4] = '{64, 96, 32, 11};
        vecs[5] = '{255, 255, 255, 3};
        vecs[6] = '{1, 254, 1, 16};
        vecs[7] = '{128, 128, 128, 10};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_in_ready", int'(in_ready_o), 1);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_res", int'(res_o), 0);
        check("rst_iter", int'(iter_o), 0);
        rst_i = 1'b0;

        // Directed vectors with immediate acceptance downstream.
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].a, vecs[i].b, res, iter, lat, viol);
            check($sformatf("vec%0d_res", i), res, vecs[i].res);
            check($sformatf("vec%0d_iter", i), iter, vecs[i].iter);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].iter + 2);
            check($sformatf("vec%0d_ready_low_busy", i), viol, 0);
            check($sformatf("vec%0d_ready_low_done", i), int'(in_ready_o), 0);
            @(posedge clk_i);
            @(negedge clk_i);
            check($sformatf("vec%0d_valid_after", i), int'(out_valid_o), 0);
            check($sformatf("vec%0d_ready_after", i), int'(in_ready_o), 1);
        end

        // Back-pressure: stall 10 cycles while a competing pair is offered.
        out_ready_i = 1'b0;
        do_txn(48, 18, res, iter, lat, viol);
        check("bp_res", res, 6);
        viol = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid_i = 1'b1;
            a_i = 8'd100;
            b_i = 8'd75;
            @(posedge clk_i);
            @(negedge clk_i);
            if (!out_valid_o || in_ready_o || res_o != 8'd6 || int'(iter_o) != iter) viol++;
        end
        check("bp_stall_stable", viol, 0);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("bp_release_valid", int'(out_valid_o), 0);
        check("bp_release_ready", int'(in_ready_o), 1);
        viol = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (out_valid_o || busy_o) viol++;
        end
        check("bp_ignored_pair", viol, 0);

        // Asynchronous reset while iterating on (255,1).
        @(negedge clk_i);
        a_i = 8'd255;
        b_i = 8'd1;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("mid_busy", int'(busy_o), 1);
        check("mid_valid", int'(out_valid_o), 0);
        #1 rst_i = 1'b1;
        #1;
        check("arst_valid", int'(out_valid_o), 0);
        check("arst_ready", int'(in_ready_o), 1);
        check("arst_busy", int'(busy_o), 0);
        check("arst_res", int'(res_o), 0);
        check("arst_iter", int'(iter_o), 0);
        @(negedge clk_i);
        check("arst_hold_valid", int'(out_valid_o), 0);
        rst_i = 1'b0;
        do_txn(21, 14, res, iter, lat, viol);
        check("post_rst_res", res, 7);
        @(posedge clk_i);

        // Random soak against the Euclid reference, in-order scoreboard.
        rcvd    = 0;
        cyc     = 0;
        timeout = 1'b0;
        fork
            begin
                for (int i = 0; i < N_SOAK && !timeout; i++) begin
                    int ra = int'($urandom_range(255));
                    int rb = int'($urandom_range(255));
                    @(negedge clk_i);
                    in_valid_i = 1'b0;
                    if ($urandom_range(3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
                    a_i = W'(ra);
                    b_i = W'(rb);
                    in_valid_i = 1'b1;
                    while (!in_ready_o && !timeout) @(negedge clk_i);
                    if (!timeout) exp_q.push_back(ref_gcd(ra, rb));
                    @(posedge clk_i);
                end
                @(negedge clk_i);
                in_valid_i = 1'b0;
            end
            begin
                bit           stalled = 1'b0;
                logic [W-1:0] held = '0;
                while (rcvd < N_SOAK && !timeout) begin
                    @(negedge clk_i);
                    cyc++;
                    if (cyc > BUDGET) timeout = 1'b1;
                    if (stalled) begin
                        check("soak_hold_valid", int'(out_valid_o), 1);
                        check("soak_hold_res", int'(res_o), int'(held));
                    end
                    out_ready_i = ($urandom_range(3) != 0);
                    stalled = 1'b0;
                    if (out_valid_o) begin
                        if (out_ready_i) begin
                            check("soak_expected_pending", int'(exp_q.size() > 0), 1);
                            if (exp_q.size() > 0) check("soak_res", int'(res_o), exp_q.pop_front());
                            check("soak_iter_bound", int'(int'(iter_o) <= ITER_MAX), 1);
                            rcvd++;
                        end else begin
                            stalled = 1'b1;
                            held = res_o;
                        end
                    end
                end
            end
        join
        check("soak_timeout", int'(timeout), 0);
        check("soak_count", rcvd, N_SOAK);
        check("soak_leftover", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
